// File: rtl/key_conditioner.sv
// key_conditioner
//   Input conditioning for the board-level pushbuttons and slide switches.
//   Every raw input passes through a 2-FF synchroniser. Each active-low KEY
//   is then debounced by its own key_fsm instance. That instance produces a
//   clean level plus one-cycle press, release and auto-repeat pulses.
//
// Ports
//   CLK          system clock
//   RST_N        asynchronous active-low reset
//   KEY          raw pushbuttons, active-low, asynchronous
//   SW           raw slide switches, asynchronous
//   REPEAT_EN    synchronous enable for auto-repeat on all keys
//   SW_SYNC      synchronised switches
//   KEY_LEVEL    debounced key state, 1 = pressed
//   KEY_PRESS    one-cycle pulse on accepted press
//   KEY_RELEASE  one-cycle pulse on accepted release
//   KEY_REPEAT   one-cycle auto-repeat pulse while held

module key_fsm #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p_i,          // synchronised, active-high pressed
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic rpt_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int PW = $clog2(REPEAT_PERIOD);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HCNT_SAT  = HW'(REPEAT_DELAY);
  localparam logic [PW-1:0] PCNT_LAST = PW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            rpt_q, rpt_d;
  logic            rpt_due;

  // The hold schedule has two phases. hcnt counts the initial delay and
  // saturates at REPEAT_DELAY. After that, pcnt wraps with the repeat period.
  // A long hold therefore never wraps back into the initial-delay window.
  // Both counters only advance on HELD cycles where the key is still down.
  // A bounce into RELEASE_WAIT simply pauses the schedule.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    rpt_due = 1'b0;
    case (state_q)
      IDLE: begin
        if (p_i) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!p_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          hcnt_d  = '0;
          pcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!p_i) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end else begin
          if (hcnt_q != HCNT_SAT) begin
            hcnt_d  = hcnt_q + HW'(1);
            pcnt_d  = '0;
            rpt_due = (hcnt_q == HCNT_LAST);
          end else begin
            pcnt_d  = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PW'(1);
            rpt_due = (pcnt_q == PCNT_LAST);
          end
          // Counters keep running when repeat is disabled. Pulses then
          // resume on the original schedule.
          rpt_d = rpt_due & repeat_en_i;
        end
      end
      RELEASE_WAIT: begin
        if (p_i) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
          hcnt_d  = '0;
          pcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign rpt_o   = rpt_q;

endmodule

module key_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_SW-1:0]   SW,
  input  logic                REPEAT_EN,
  output logic [NUM_SW-1:0]   SW_SYNC,
  output logic [NUM_KEYS-1:0] KEY_LEVEL,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_RELEASE,
  output logic [NUM_KEYS-1:0] KEY_REPEAT
);

  logic [NUM_KEYS-1:0] key_s1_q, key_s1_d;
  logic [NUM_KEYS-1:0] key_s2_q, key_s2_d;
  logic [NUM_SW-1:0]   sw_s1_q, sw_s1_d;
  logic [NUM_SW-1:0]   sw_s2_q, sw_s2_d;
  logic [NUM_KEYS-1:0] key_p;

  always_comb begin
    key_s1_d = KEY;
    key_s2_d = key_s1_q;
    sw_s1_d  = SW;
    sw_s2_d  = sw_s1_q;
  end

  // The key chain resets to 1 (released). A key held through reset is then
  // seen as a fresh press and debounced normally, so no pulse appears at
  // reset exit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_s1_q <= '1;
      key_s2_q <= '1;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
    end
  end

  assign key_p   = ~key_s2_q;
  assign SW_SYNC = sw_s2_q;

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_key
      key_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_key (
        .clk         (CLK),
        .rst_n       (RST_N),
        .p_i         (key_p[g]),
        .repeat_en_i (REPEAT_EN),
        .level_o     (KEY_LEVEL[g]),
        .press_o     (KEY_PRESS[g]),
        .rel_o       (KEY_RELEASE[g]),
        .rpt_o       (KEY_REPEAT[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short debounce and repeat timings.
// The stimulus process pushes each expected pulse (edge number, kind, mask)
// into a scoreboard queue. A monitor process pops one entry for every pulse
// the DUT shows and compares it. The monitor also flags entries whose edge
// has passed without a matching pulse.

module tb_key_conditioner;

  localparam int NK = 2;
  localparam int NS = 10;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [NK-1:0] KEY;
  logic [NS-1:0] SW;
  logic          REPEAT_EN;
  logic [NS-1:0] SW_SYNC;
  logic [NK-1:0] KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_REPEAT;

  key_conditioner #(
    .NUM_KEYS(NK), .NUM_SW(NS), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .KEY(KEY), .SW(SW), .REPEAT_EN(REPEAT_EN),
    .SW_SYNC(SW_SYNC), .KEY_LEVEL(KEY_LEVEL), .KEY_PRESS(KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE), .KEY_REPEAT(KEY_REPEAT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          edge_n;
    int          kind;   // 0 press, 1 release, 2 repeat
    logic [1:0]  mask;
  } ev_t;

  ev_t sb[$];
  int  edge_n = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge CLK) edge_n++;

  function automatic string kname(int k);
    return (k == 0) ? "press" : (k == 1) ? "release" : "repeat";
  endfunction

  function automatic void expect_ev(int e, int k, logic [1:0] m);
    ev_t ev;
    ev.edge_n = e;
    ev.kind   = k;
    ev.mask   = m;
    sb.push_back(ev);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor
  ev_t         mon_ev;
  logic [1:0]  mon_m;

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      if (sb[0].edge_n < edge_n) begin
        mon_ev = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_%s: no pulse seen, expected mask %b at edge %0d",
                 kname(mon_ev.kind), mon_ev.mask, mon_ev.edge_n);
      end
    end
    for (int k = 0; k < 3; k++) begin
      mon_m = (k == 0) ? KEY_PRESS : (k == 1) ? KEY_RELEASE : KEY_REPEAT;
      if (mon_m != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_%s at edge %0d: got mask %b, expected no pulse",
                   kname(k), edge_n, mon_m);
        end else begin
          mon_ev = sb.pop_front();
          if (mon_ev.edge_n != edge_n || mon_ev.kind != k || mon_ev.mask != mon_m) begin
            errors++;
            $display("FAIL event_%s: got mask %b at edge %0d, expected %s mask %b at edge %0d",
                     kname(k), mon_m, edge_n, kname(mon_ev.kind), mon_ev.mask, mon_ev.edge_n);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int t0, r0, u0, u1, w0;

  initial begin
    KEY = '1; SW = '0; REPEAT_EN = 1'b1; RST_N = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    chk("reset_level", 32'(KEY_LEVEL), 0);
    chk("reset_pulses", 32'({KEY_PRESS, KEY_RELEASE, KEY_REPEAT}), 0);
    chk("reset_sw_sync", 32'(SW_SYNC), 0);
    SW = 10'h3FF;
    step(3);
    chk("sw_sync_held_in_reset", 32'(SW_SYNC), 0);
    SW = '0; RST_N = 1'b1;
    step(4);

    // 1: short glitch rejected
    KEY[0] = 1'b0; step(2); KEY[0] = 1'b1;
    step(10);
    chk("glitch_level", 32'(KEY_LEVEL), 0);

    // 2/3: press, repeats, repeat disable and resume
    t0 = edge_n; KEY[0] = 1'b0;
    expect_ev(t0 + 6, 0, 2'b01);
    expect_ev(t0 + 26, 2, 2'b01);
    expect_ev(t0 + 34, 2, 2'b01);
    expect_ev(t0 + 42, 2, 2'b01);
    step(5);
    chk("level_before_press", 32'(KEY_LEVEL), 0);
    step(2);
    chk("level_after_press", 32'(KEY_LEVEL), 32'h1);
    step(37);
    REPEAT_EN = 1'b0;
    step(16);
    REPEAT_EN = 1'b1;
    expect_ev(t0 + 66, 2, 2'b01);
    step(8);
    chk("level_held", 32'(KEY_LEVEL), 32'h1);

    // 4: bouncy release
    r0 = edge_n; KEY[0] = 1'b1;
    step(2); KEY[0] = 1'b0;
    step(1); KEY[0] = 1'b1;
    expect_ev(r0 + 9, 1, 2'b01);
    step(5);
    chk("level_before_release", 32'(KEY_LEVEL), 32'h1);
    step(2);
    chk("level_after_release", 32'(KEY_LEVEL), 0);
    step(4);

    // 5: reset while held, key still down at reset exit
    u0 = edge_n; KEY[0] = 1'b0;
    expect_ev(u0 + 6, 0, 2'b01);
    step(10);
    chk("level_held_pre_reset", 32'(KEY_LEVEL), 32'h1);
    RST_N = 1'b0;
    #1;
    chk("level_async_reset", 32'(KEY_LEVEL), 0);
    step(2);
    RST_N = 1'b1;
    u1 = edge_n;
    expect_ev(u1 + 6, 0, 2'b01);
    step(5);
    chk("level_post_reset_early", 32'(KEY_LEVEL), 0);
    step(5);
    chk("level_post_reset_press", 32'(KEY_LEVEL), 32'h1);
    KEY[0] = 1'b1;
    expect_ev(u1 + 16, 1, 2'b01);
    step(10);

    // 6: both keys together, switch sync
    w0 = edge_n; KEY = 2'b00; SW = 10'h35F;
    expect_ev(w0 + 6, 0, 2'b11);
    step(1);
    chk("sw_sync_one_edge", 32'(SW_SYNC), 0);
    step(1);
    chk("sw_sync_two_edges", 32'(SW_SYNC), 32'h35F);
    step(6);
    chk("level_both", 32'(KEY_LEVEL), 32'h3);
    KEY = 2'b11; SW = 10'h2A5;
    expect_ev(w0 + 14, 1, 2'b11);
    step(2);
    chk("sw_sync_second", 32'(SW_SYNC), 32'h2A5);
    step(10);
    chk("level_both_released", 32'(KEY_LEVEL), 0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
